// File: rtl/buf_arb_pkg.sv
// +--------------------------------------------------------------------+
// | buf_arb_pkg : shared types and helpers for buf_share_arbiter       |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package buf_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic IDLE_VAL_DEFAULT = 1'b0;

  // Index width for N requesters, never narrower than one bit.
  function automatic int ow_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +--------------------------------------------------------------------+
// | rr_pick  : combinational round-robin picker, scans up from ptr     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import buf_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int OW = ow_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          valid,
  output logic [OW-1:0] idx
);

  logic [N-1:0] w_cand;
  assign w_cand = req & ~mask;

  // Scan offsets high to low so the closest candidate to ptr wins last.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (w_cand[j]) begin
        valid = 1'b1;
        idx   = OW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/buf_share_arbiter.sv
// +--------------------------------------------------------------------+
// | buf_share_arbiter : round-robin owner of one registered 1-bit line |
// | Option: BUF_ARB_TIMEOUT_EN adds a MAX_HOLD preemption counter      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module buf_share_arbiter
  import buf_arb_pkg::*;
#(
  parameter  int   N        = 4,
  parameter  int   MAX_HOLD = 8,
  parameter  logic IDLE_VAL = IDLE_VAL_DEFAULT,
  localparam int   OW       = ow_f(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  gnt,
  output logic          s,
  output logic          busy,
  output logic [OW-1:0] owner
);

  if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_param_check
    $error("buf_share_arbiter: illegal N or MAX_HOLD");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          s_q, s_d;
  logic          busy_q, busy_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  w_owner_oh;
  logic [OW-1:0] w_next_ptr;
  logic [OW-1:0] w_ptr;
  logic [N-1:0]  w_mask;
  logic          w_valid;
  logic [OW-1:0] w_pick;
  logic          w_timeout;
  logic          w_release;

  assign w_owner_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;
  assign w_next_ptr = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

  // One picker serves both cases: fresh pick from ptr when idle,
  // handoff pick past (and excluding) the owner while granting.
  assign w_ptr  = (state_q == ST_GRANT) ? w_next_ptr : ptr_q;
  assign w_mask = (state_q == ST_GRANT) ? w_owner_oh : '0;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (w_ptr),
    .mask (w_mask),
    .valid(w_valid),
    .idx  (w_pick)
  );

`ifdef BUF_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
  assign w_timeout = (hold_q == HW'(MAX_HOLD - 1)) && w_valid;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_release = (state_q == ST_GRANT) && (!req[owner_q] || w_timeout);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef BUF_ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    if (w_release) ptr_d = w_next_ptr;

    if (w_valid && (state_q == ST_IDLE || w_release)) begin
      state_d        = ST_GRANT;
      gnt_d          = '0;
      gnt_d[w_pick]  = 1'b1;
      owner_d        = w_pick;
      busy_d         = 1'b1;
      s_d            = din[w_pick];
`ifdef BUF_ARB_TIMEOUT_EN
      hold_d         = '0;
`endif
    end else if (w_release) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      s_d     = IDLE_VAL;
    end else if (state_q == ST_GRANT) begin
      s_d = din[owner_q];
`ifdef BUF_ARB_TIMEOUT_EN
      if (hold_q != HW'(MAX_HOLD - 1)) hold_d = hold_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      s_q     <= IDLE_VAL;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
`ifdef BUF_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
`ifdef BUF_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_buf_share_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_buf_share_arbiter : scoreboard bench for buf_share_arbiter, N=4 |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_buf_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] gnt;
  logic       s;
  logic       busy;
  logic [1:0] owner;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] din;
    logic [7:0] expv;   // {gnt, owner, busy, s}
  } step_t;

  step_t      stim[$];
  logic [7:0] sb[$];

  buf_share_arbiter #(.N(4), .MAX_HOLD(8), .IDLE_VAL(1'b0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .s    (s),
    .busy (busy),
    .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ((busy !== |gnt) || !$onehot0(gnt)) begin
        bad++;
        $display("FAIL invariant: gnt=%b busy=%b, required one-hot/zero gnt and busy==|gnt", gnt, busy);
      end
    end
  end

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] d,
                     input logic [3:0] g, input int o, input logic b, input logic sv);
    stim.push_back('{r, q, d, {g, 2'(o), b, sv}});
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1) << i;
  endfunction

  task automatic test_reset();
    logic [7:0] e, got;
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst_n; req = stim[i].req; din = stim[i].din;
      sb.push_back(stim[i].expv);
      @(posedge clk); #1;
      got = {gnt, owner, busy, s};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset step %0d: got gnt/owner/busy/s=%b required %b", i, got, e);
      end
    end
    stim.delete();
    chk_en = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] e, got;
    add(1, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1);
    add(1, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
    add(1, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1);
    add(1, 4'b0100, 4'b1011, 4'b0100, 2, 1, 0);
    add(1, 4'b0100, 4'b0100, 4'b0100, 2, 1, 1);
    add(1, 4'b0000, 4'b1111, 4'b0000, 2, 0, 0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst_n; req = stim[i].req; din = stim[i].din;
      sb.push_back(stim[i].expv);
      @(posedge clk); #1;
      got = {gnt, owner, busy, s};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL single step %0d: got gnt/owner/busy/s=%b required %b", i, got, e);
      end
    end
    stim.delete();
  endtask

  task automatic test_round_robin();
    logic [7:0] e, got;
    logic [3:0] d;
    d = 4'b1010;
    add(0, 4'b0000, d, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, d, 4'b0001, 0, 1, d[0]);
    for (int o = 0; o < 4; o++) begin
      add(1, 4'b1111, d, oh(o), o, 1, d[o]);
      add(1, 4'b1111 & ~oh(o), d, oh((o + 1) % 4), (o + 1) % 4, 1, d[(o + 1) % 4]);
    end
    add(1, 4'b0000, d, 4'b0000, 0, 0, 0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst_n; req = stim[i].req; din = stim[i].din;
      sb.push_back(stim[i].expv);
      @(posedge clk); #1;
      got = {gnt, owner, busy, s};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL round_robin step %0d: got gnt/owner/busy/s=%b required %b", i, got, e);
      end
    end
    stim.delete();
  endtask

  task automatic test_handoff();
    logic [7:0] e, got;
    add(1, 4'b0010, 4'b1010, 4'b0010, 1, 1, 1);
    add(1, 4'b1010, 4'b1010, 4'b0010, 1, 1, 1);
    add(1, 4'b1000, 4'b1010, 4'b1000, 3, 1, 1);
    add(1, 4'b0000, 4'b1010, 4'b0000, 3, 0, 0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst_n; req = stim[i].req; din = stim[i].din;
      sb.push_back(stim[i].expv);
      @(posedge clk); #1;
      got = {gnt, owner, busy, s};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL handoff step %0d: got gnt/owner/busy/s=%b required %b", i, got, e);
      end
    end
    stim.delete();
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] e, got;
    add(1, 4'b0100, 4'b0110, 4'b0100, 2, 1, 1);
    add(1, 4'b0100, 4'b0110, 4'b0100, 2, 1, 1);
    add(0, 4'b0100, 4'b0110, 4'b0000, 0, 0, 0);
    add(1, 4'b0110, 4'b0110, 4'b0010, 1, 1, 1);
    add(1, 4'b0000, 4'b0110, 4'b0000, 1, 0, 0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst_n; req = stim[i].req; din = stim[i].din;
      sb.push_back(stim[i].expv);
      @(posedge clk); #1;
      got = {gnt, owner, busy, s};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_mid step %0d: got gnt/owner/busy/s=%b required %b", i, got, e);
      end
    end
    stim.delete();
  endtask

  task automatic test_timeout();
    logic [7:0] e, got;
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0);
`ifdef BUF_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) add(1, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0101, 4'b0000, 4'b0100, 2, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 2, 0, 0);
`else
    for (int i = 0; i < 20; i++) add(1, 4'b0101, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
`endif
    add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 24; i++) add(1, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    foreach (stim[i]) begin
      rst_n = stim[i].rst_n; req = stim[i].req; din = stim[i].din;
      sb.push_back(stim[i].expv);
      @(posedge clk); #1;
      got = {gnt, owner, busy, s};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL timeout step %0d: got gnt/owner/busy/s=%b required %b", i, got, e);
      end
    end
    stim.delete();
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_handoff();
    test_reset_mid_grant();
    test_timeout();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buf_share_arbiter.md
Name: buf_share_arbiter

Overview:
- Round-robin arbiter that shares one 1-bit buffered output line among N requesters.
- Each requester raises req[i] and drives din[i]. The arbiter grants exactly one owner and registers din[owner] onto s.
- Sits in front of the single-bit buffer path, so several sources can take turns driving one output line without contention.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 8, maximum grant length in cycles when the timeout feature is compiled in; must be ≥2.
- IDLE_VAL, 1'b0, value driven on s when no grant is active.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset; sampled at posedge clk.
- req  input  N  request lines, one per requester; level-sensitive.
- din  input  N  data bit per requester; only din[owner] is used.
- gnt  output  N  one-hot grant, or all-zero; registered.
- s  output  1  shared buffered output line; registered.
- busy  output  1  high while any grant is active; registered.
- owner  output  OW  index of the current/last grantee, where OW = max(1, $clog2(N)); registered.

Behaviour:
- Reset: rst_n low at a posedge sets gnt=0, s=IDLE_VAL, busy=0, owner=0, rr pointer=0, state=IDLE, hold counter=0. Reset mid-grant drops gnt at that same edge; no handoff occurs.
- States: IDLE, GRANT. Encoding is 1 bit.
- Round-robin pick: select the first asserted bit scanning from the pointer upward, wrapping N-1 → 0.
- IDLE:
  - If req != 0 at a posedge, go to GRANT at that edge.
  - Set gnt = onehot(pick), owner = pick, busy = 1.
  - Latency: req seen at edge k → gnt visible after edge k.
  - If req == 0, stay in IDLE.
- GRANT, hold case: while req[owner]=1, keep gnt/owner unchanged.
- GRANT, release case: when req[owner]=0 at a posedge, the grant is released at that edge, with handoff to the next requester.
  - Pointer becomes (owner+1) mod N.
  - Pick among req with bit owner masked. If a pick exists, issue the new grant at the same edge with no idle gap; otherwise go to IDLE with gnt=0 and busy=0.
  - owner keeps the last grantee in IDLE.
- Data path:
  - In GRANT, s <= din[owner] each cycle, so s lags din by 1 cycle.
  - On the edge that enters GRANT, s <= din[pick].
  - On the edge that enters IDLE, s <= IDLE_VAL.
- Simultaneous events:
  - Owner drop coincides with new requests rising: handoff considers all requests sampled at that edge.
  - All requesters rise together from IDLE: the pointer decides.
- Invariant: gnt is one-hot or zero every cycle; busy == |gnt.
- req changes from non-owners while a grant is held have no effect.

Optional Feature:
- Macro: BUF_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each GRANT cycle.
  - When counter == MAX_HOLD-1 and some other req bit is set, force a release at that edge, following the normal handoff rules; the preempted owner is masked.
  - If no other request is pending, the grant continues and the counter saturates at MAX_HOLD-1.
  - The preempted requester may re-win later under round-robin.
- Undefined: no counter is present, MAX_HOLD is unused, and a grant is held until req[owner] drops.

Decomposition:
- Shared package buf_arb_pkg holds:
  - state localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - the OW width function (clog2 with a floor of 1);
  - IDLE_VAL default.
- One sub-module: rr_pick (combinational). Inputs req[N], ptr[OW], mask[N]; outputs valid and idx[OW]. Instantiated once and used for both the IDLE pick and the handoff pick.

Test Plan:
- Reset and single request (N=4):
  - Hold rst_n=0 for 2 cycles → gnt=0000, s=0, busy=0.
  - Release reset, assert req=0100, din[2] toggling → gnt=0100 one edge later, owner=2, s follows din[2] with 1-cycle lag.
- Round-robin fairness:
  - req=1111 held; each owner drops its req after 2 cycles, then re-raises it.
  - Grant order 0,1,2,3,0 with no idle cycle between grants.
- Handoff and release:
  - Owner 1 drops while req[3]=1 → same edge gnt=1000, owner=3.
  - Owner 3 drops with req=0 → gnt=0000, busy=0, s=IDLE_VAL, owner stays 3.
- Reset mid-grant:
  - Owner 2 active, drive rst_n=0 for one edge → gnt=0000, s=0, pointer=0.
  - Next request set req=0110 → owner=1.
- Timeout (BUF_ARB_TIMEOUT_EN, MAX_HOLD=8):
  - req[0] held forever with req[2]=1 → gnt moves to 0100 after exactly 8 grant cycles.
  - With req[0] alone, the grant persists beyond 20 cycles.
  - Same stimulus without the macro → owner 0 is never preempted.
